// File: rtl/memory_burst_writer_pkg.sv
// Shared constants, field offsets and FSM encoding for the SDRAM burst write and read paths.
package memory_burst_writer_pkg;

    localparam int DEF_BYTES_PER_ADDR = 32;
    localparam int DEF_BURST_N        = 128;

    localparam int SDRAM_ADDR_W = 27;
    localparam int BURSTCOUNT_W = 8;
    localparam int COUNT_W      = 32;
    localparam int FIELD_W      = 32;

    // Command word: {byte size, byte address}; status word: {bytes written, tag}
    localparam int CMD_ADDR_LSB  = 0;
    localparam int CMD_SIZE_LSB  = 32;
    localparam int STAT_TAG_LSB  = 0;
    localparam int STAT_SIZE_LSB = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BURST  = 2'd2,
        STATUS = 2'd3
    } burst_state_t;

    function automatic logic [COUNT_W-1:0] min_count(input logic [COUNT_W-1:0] a,
                                                     input logic [COUNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Start address and length of the burst that begins at beat beats_done of a job.
module burst_addr_gen
    import memory_burst_writer_pkg::*;
#(
    parameter int BURST_N = DEF_BURST_N
)(
    input  logic [COUNT_W-1:0]      base,
    input  logic [COUNT_W-1:0]      beats_done,
    input  logic [COUNT_W-1:0]      beats,
    output logic [SDRAM_ADDR_W-1:0] address,
    output logic [BURSTCOUNT_W-1:0] burstcount
);

    logic [COUNT_W-1:0] remaining;

    assign remaining  = beats - beats_done;
    // Word address wraps modulo the SDRAM address space
    assign address    = SDRAM_ADDR_W'(base + beats_done);
    assign burstcount = BURSTCOUNT_W'(min_count(remaining, COUNT_W'(BURST_N)));

endmodule

// File: rtl/memory_burst_writer.sv
// Pulls write jobs from a command FIFO, streams result beats into SDRAM as Avalon-MM
// bursts with no internal buffering, and posts a status word per completed job.
module memory_burst_writer
    import memory_burst_writer_pkg::*;
#(
    parameter int BYTES_PER_ADDR = DEF_BYTES_PER_ADDR,
    parameter int BURST_N        = DEF_BURST_N
)(
    input  logic         CLOCK,
    input  logic         reset_n,
    input  logic [31:0]  in_count,
    output logic         fifo_in_read,
    input  logic [63:0]  fifo_in_readdata,
    input  logic         fifo_in_waitrequest,
    output logic         fifo_out_write,
    output logic [63:0]  fifo_out_writedata,
    input  logic         fifo_out_waitrequest,
    input  logic [255:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [26:0]  sdram1_data_address,
    output logic [7:0]   sdram1_data_burstcount,
    output logic         sdram1_data_write,
    output logic [255:0] sdram1_data_writedata,
    output logic [31:0]  sdram1_data_byteenable,
    input  logic         sdram1_data_waitrequest,
    output logic         is_writing
);

    localparam int ADDR_SHIFT = $clog2(BYTES_PER_ADDR);

    burst_state_t state_reg, state_next;

    logic                    fifo_in_read_reg, fifo_in_read_next;
    logic                    fifo_out_write_reg, fifo_out_write_next;
    logic                    is_writing_reg, is_writing_next;
    logic                    write_reg, write_next;
    logic [255:0]            writedata_reg, writedata_next;
    logic [SDRAM_ADDR_W-1:0] address_reg, address_next;
    logic [BURSTCOUNT_W-1:0] burstcount_reg, burstcount_next;
    logic [COUNT_W-1:0]      base_reg, base_next;
    logic [COUNT_W-1:0]      beats_reg, beats_next;
    logic [COUNT_W-1:0]      beats_done_reg, beats_done_next;
    logic [COUNT_W-1:0]      burst_beat_reg, burst_beat_next;

    logic [COUNT_W-1:0]      cmd_addr, cmd_size, cmd_base, cmd_beats;
    logic [COUNT_W-1:0]      issued, issued_in_burst;
    logic [SDRAM_ADDR_W-1:0] gen_address;
    logic [BURSTCOUNT_W-1:0] gen_burstcount;
    logic                    complete, ready, accept;

    assign cmd_addr  = fifo_in_readdata[CMD_ADDR_LSB +: FIELD_W];
    assign cmd_size  = fifo_in_readdata[CMD_SIZE_LSB +: FIELD_W];
    assign cmd_base  = cmd_addr >> ADDR_SHIFT;
    assign cmd_beats = cmd_size >> ADDR_SHIFT;

    // At most one beat is in flight, so accepted = completed + pending
    assign issued          = beats_done_reg + COUNT_W'(write_reg);
    assign issued_in_burst = burst_beat_reg + COUNT_W'(write_reg);

    assign complete = write_reg && !sdram1_data_waitrequest;
    assign ready    = (state_reg == BURST) && (!write_reg || !sdram1_data_waitrequest)
                      && (issued < beats_reg);
    assign accept   = wr_valid && ready;

    burst_addr_gen #(
        .BURST_N    (BURST_N)
    ) u_addr_gen (
        .base       (base_reg),
        .beats_done (issued),
        .beats      (beats_reg),
        .address    (gen_address),
        .burstcount (gen_burstcount)
    );

    always_comb begin
        state_next          = state_reg;
        fifo_in_read_next   = fifo_in_read_reg;
        fifo_out_write_next = fifo_out_write_reg;
        is_writing_next     = is_writing_reg;
        write_next          = write_reg;
        writedata_next      = writedata_reg;
        address_next        = address_reg;
        burstcount_next     = burstcount_reg;
        base_next           = base_reg;
        beats_next          = beats_reg;
        beats_done_next     = beats_done_reg;
        burst_beat_next     = burst_beat_reg;

        case (state_reg)
            IDLE: begin
                fifo_in_read_next = 1'b1;
                state_next        = FETCH;
            end
            FETCH: begin
                if (fifo_in_read_reg && !fifo_in_waitrequest && (fifo_in_readdata != '0)) begin
                    fifo_in_read_next = 1'b0;
                    is_writing_next   = 1'b1;
                    base_next         = cmd_base;
                    beats_next        = cmd_beats;
                    beats_done_next   = '0;
                    burst_beat_next   = '0;
                    // Zero burstcount forces the first accepted beat to open a burst
                    burstcount_next   = '0;
                    if (cmd_beats == '0) begin
                        fifo_out_write_next = 1'b1;
                        state_next          = STATUS;
                    end else begin
                        state_next = BURST;
                    end
                end
            end
            BURST: begin
                beats_done_next = beats_done_reg + COUNT_W'(complete);
                burst_beat_next = burst_beat_reg + COUNT_W'(complete);
                if (accept) begin
                    write_next     = 1'b1;
                    writedata_next = wr_data;
                    if (issued_in_burst == COUNT_W'(burstcount_reg)) begin
                        address_next    = gen_address;
                        burstcount_next = gen_burstcount;
                        burst_beat_next = '0;
                    end
                end else if (complete) begin
                    write_next = 1'b0;
                end
                if (complete && (beats_done_reg + COUNT_W'(1) == beats_reg)) begin
                    write_next          = 1'b0;
                    fifo_out_write_next = 1'b1;
                    state_next          = STATUS;
                end
            end
            STATUS: begin
                if (fifo_out_write_reg && !fifo_out_waitrequest) begin
                    fifo_out_write_next = 1'b0;
                    is_writing_next     = 1'b0;
                    state_next          = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            fifo_in_read_reg   <= 1'b0;
            fifo_out_write_reg <= 1'b0;
            is_writing_reg     <= 1'b0;
            write_reg          <= 1'b0;
            writedata_reg      <= '0;
            address_reg        <= '0;
            burstcount_reg     <= '0;
            base_reg           <= '0;
            beats_reg          <= '0;
            beats_done_reg     <= '0;
            burst_beat_reg     <= '0;
        end else begin
            state_reg          <= state_next;
            fifo_in_read_reg   <= fifo_in_read_next;
            fifo_out_write_reg <= fifo_out_write_next;
            is_writing_reg     <= is_writing_next;
            write_reg          <= write_next;
            writedata_reg      <= writedata_next;
            address_reg        <= address_next;
            burstcount_reg     <= burstcount_next;
            base_reg           <= base_next;
            beats_reg          <= beats_next;
            beats_done_reg     <= beats_done_next;
            burst_beat_reg     <= burst_beat_next;
        end
    end

    always_comb begin
        fifo_out_writedata = '0;
        if (fifo_out_write_reg) begin
            fifo_out_writedata[STAT_TAG_LSB +: FIELD_W]  = in_count;
            fifo_out_writedata[STAT_SIZE_LSB +: FIELD_W] = beats_done_reg << ADDR_SHIFT;
        end
    end

    assign fifo_in_read           = fifo_in_read_reg;
    assign fifo_out_write         = fifo_out_write_reg;
    assign is_writing             = is_writing_reg;
    assign wr_ready               = ready;
    assign sdram1_data_write      = write_reg;
    assign sdram1_data_writedata  = writedata_reg;
    assign sdram1_data_address    = address_reg;
    assign sdram1_data_burstcount = burstcount_reg;
    assign sdram1_data_byteenable = '1;

endmodule

// File: doc/memory_burst_writer.md
MEMORY_BURST_WRITER -- requirements
Module: memory_burst_writer

Interface
REQ-001 The block SHALL use reset reset_n, asynchronous, active-low; clock CLOCK.
REQ-002 Parameters SHALL be, one per line:
- BYTES_PER_ADDR, 32, bytes per SDRAM word address.
- BURST_N, 128, maximum beats per burst.
REQ-003 Ports SHALL be, one per line:
- CLOCK  in  1  rising-edge clock.
- reset_n  in  1  async active-low reset.
- in_count  in  32  free-running tag copied into status words.
- fifo_in_read  out  1  command FIFO read request.
- fifo_in_readdata  in  64  command: [31:0] byte address, [63:32] byte size.
- fifo_in_waitrequest  in  1  command FIFO stall.
- fifo_out_write  out  1  status FIFO write request.
- fifo_out_writedata  out  64  status word.
- fifo_out_waitrequest  in  1  status FIFO stall.
- wr_data  in  256  result stream data.
- wr_valid  in  1  result stream valid.
- wr_ready  out  1  result stream ready.
- sdram1_data_address  out  27  Avalon-MM word address.
- sdram1_data_burstcount  out  8  burst length in beats.
- sdram1_data_write  out  1  write request.
- sdram1_data_writedata  out  256  write data.
- sdram1_data_byteenable  out  32  always all ones.
- sdram1_data_waitrequest  in  1  slave stall.
- is_writing  out  1  job in progress.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, BURST and STATUS.
REQ-005 IDLE: the FSM SHALL assert fifo_in_read and enter FETCH.
REQ-006 FETCH: when fifo_in_read && !fifo_in_waitrequest, the block SHALL handle the command as follows:
- Zero command word: discard and remain in FETCH.
- Otherwise: latch base = addr/32 and beats = size/32 (floor), deassert fifo_in_read, set is_writing=1.
- beats==0: go to STATUS.
- Otherwise: go to BURST.
REQ-007 Each burst SHALL start at address base+beats_done with burstcount = min(BURST_N, beats_remaining); address and burstcount SHALL stay constant for all beats of the burst.
REQ-008 The block SHALL set wr_ready = BURST && (!sdram1_data_write || !sdram1_data_waitrequest), so data flows straight through with zero added latency and no internal buffer.
REQ-009 A beat SHALL be accepted when wr_valid && wr_ready; it SHALL load writedata and assert write on the next cycle.
REQ-010 While sdram1_data_waitrequest is high, write, writedata, address and burstcount SHALL hold unchanged.
REQ-011 A beat SHALL complete when write && !waitrequest; beats_done and burst_beat SHALL increment by 1.
REQ-012 When wr_valid is low, write SHALL deassert between beats (legal Avalon idle); address and burstcount SHALL be held.
REQ-013 When burst_beat reaches the burstcount, the next beat SHALL open a new burst (REQ-007) with no idle cycle required.
REQ-014 When beats_done reaches beats, the block SHALL deassert write and wr_ready and go to STATUS.
REQ-015 STATUS: the block SHALL drive fifo_out_writedata = {beats_done*32, in_count}, hold fifo_out_write until !fifo_out_waitrequest, then clear is_writing and return to IDLE.
REQ-016 Counters SHALL be 32-bit; address SHALL be base+beats_done truncated to 27 bits, so it wraps modulo 2^27.
REQ-017 sdram1_data_byteenable SHALL be constant 32'hFFFF_FFFF.

Reset
REQ-018 On reset, the following SHALL be 0: all outputs, all counters, is_writing, wr_ready, fifo_in_read, fifo_out_write, sdram1_data_write and sdram1_data_burstcount; the state SHALL be IDLE.
REQ-019 Reset asserted mid-burst SHALL abandon the burst immediately; no status word SHALL be emitted for it.
REQ-020 The block SHALL assert fifo_in_read on the first clock after reset_n rises.

Structure
REQ-021 BYTES_PER_ADDR, BURST_N, the state encoding and the command/status field offsets SHALL live in the shared package used by the matching burst read path.
REQ-022 Sub-module: burst_addr_gen SHALL compute the next address and burstcount from base, beats_done and beats.

Verification
REQ-023 A bench SHALL cover the following directed scenarios:
- Command {size=0x1000, addr=0x2000}, continuous wr_valid -> one burst, address 0x100, burstcount 128, 128 beats, status {0x1000, tag}.
- Size 0x2040 -> bursts of 128, 128, 2 beats at 0x100, 0x180, 0x200; status size 0x2040.
- waitrequest high for 3 cycles on beat 5 -> write and writedata held; no beat lost or duplicated.
- wr_valid gaps every other cycle -> write toggles; address and burstcount constant across the burst.
- Size 0x10 (below 32) -> no SDRAM write; status {0, tag}. Zero command word -> ignored, fifo_in_read stays high.
- reset_n pulsed at beat 60 -> all outputs 0 next edge; after release, fifo_in_read=1 and the next command is processed normally.
